// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble),
// one input bit per clock. Feeds a bank of 4-bit-digit to 7-segment decoders.
//
// Handshake: a start pulse while idle captures bin. BIN_W clocks later the
// digits/overflow outputs update and done pulses for one cycle. Values above
// MAXV = 10**DIGITS - 1 saturate to all 9s and raise overflow.
//
// Optional feature (macro BIN2BCD_BLANK_EN): leading-zero blanking. When
// defined, every digit above the most significant nonzero digit is replaced
// by 4'hF, which the decoder renders dark. Digit 0 is never blanked, and
// saturated 9s are never blanked. The port list is identical either way.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   conversion request, sampled only while idle
//   bin       in   [BIN_W-1:0] binary value, captured with start
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when digits/overflow update
//   digits    out  [4*DIGITS-1:0] BCD result, digits[3:0] least significant
//   overflow  out  last accepted bin exceeded MAXV
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | shifting one bit per clock into the BCD accumulator
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] digits,
    output logic                overflow
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam longint unsigned MAXV = (64'd10 ** DIGITS) - 64'd1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [BIN_W-1:0] r_sreg;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_pend;
    logic             r_done;
    logic [ACC_W-1:0] r_digits;
    logic             r_overflow;

    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_adj;
    logic [ACC_W-1:0] w_acc_shl;
    logic [ACC_W-1:0] w_disp;
    logic [ACC_W-1:0] w_result;

    assign w_ovf = (64'(bin) > MAXV);

    // Add-3 correction ahead of the shift keeps every nibble a valid BCD digit.
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Carry out of the top nibble is dropped; such inputs are saturated anyway.
    assign w_acc_shl = {w_acc_adj[ACC_W-2:0], r_sreg[BIN_W-1]};

`ifdef BIN2BCD_BLANK_EN
    function automatic logic [ACC_W-1:0] blank_lz(input logic [ACC_W-1:0] d);
        logic lead;
        blank_lz = d;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (d[4*i +: 4] == 4'h0)) begin
                blank_lz[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    endfunction

    assign w_disp = blank_lz(w_acc_shl);
`else
    assign w_disp = w_acc_shl;
`endif

    // Saturation is applied after blanking so the 9s are never blanked.
    assign w_result = r_ovf_pend ? {DIGITS{4'h9}} : w_disp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_digits   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_sreg     <= bin;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_ovf_pend <= w_ovf;
                    r_state    <= ST_SHIFT;
                end
            end else begin
                r_acc  <= w_acc_shl;
                r_sreg <= r_sreg << 1;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    r_digits   <= w_result;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            end
        end
    end

    assign busy     = (r_state == ST_SHIFT);
    assign done     = r_done;
    assign digits   = r_digits;
    assign overflow = r_overflow;

endmodule
